// File: rtl/agc_fetch_pkg.sv
// Shared types, widths and helpers for the AGC instruction fetcher.
package agc_fetch_pkg;

    localparam int AGC_WORD_W = 15;
    localparam int AGC_ADDR_W = 12;

    localparam logic [AGC_ADDR_W-1:0] DEF_RESET_PC    = 12'h800;
    localparam logic [AGC_WORD_W-1:0] DEF_EXTEND_WORD = 15'h0006;

    typedef enum logic [1:0] {START, REQ, HOLD, HALT} fetch_state_e;

    // Memory words carry odd parity over all 16 bits.
    function automatic logic odd_parity_ok(logic [15:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/agc_instr_fetcher_if.sv
// Memory, instruction and redirect handshakes of the instruction fetcher.
interface agc_instr_fetcher_if;
    import agc_fetch_pkg::*;

    logic                  mem_req;
    logic [AGC_ADDR_W-1:0] mem_addr;
    logic                  mem_ready;
    logic [15:0]           mem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [AGC_WORD_W-1:0] instr;
    logic                  instr_ext;
    logic [AGC_ADDR_W-1:0] instr_addr;
    logic                  pc_load;
    logic [AGC_ADDR_W-1:0] pc_load_addr;
    logic                  parity_err;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_ext, instr_addr, parity_err,
        input  mem_ready, mem_rdata, instr_ready, pc_load, pc_load_addr
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_ext, instr_addr, parity_err,
        output mem_ready, mem_rdata, instr_ready, pc_load, pc_load_addr
    );

endinterface

// File: rtl/agc_instr_fetcher.sv
// Sequential AGC instruction fetcher: parity check, EXTEND folding, redirect,
// and a one-entry valid/ready output buffer.
module agc_instr_fetcher
    import agc_fetch_pkg::*;
#(
    parameter logic [AGC_ADDR_W-1:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [AGC_WORD_W-1:0] EXTEND_WORD = DEF_EXTEND_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    agc_instr_fetcher_if.master bus
);

    fetch_state_e          state, state_nxt;
    logic [AGC_ADDR_W-1:0] pc, pc_nxt;
    logic                  ext_flag, ext_nxt;
    logic                  redir_pend, pend_nxt;
    logic [AGC_ADDR_W-1:0] redir_addr, raddr_nxt;
    logic                  perr, perr_nxt;
    logic                  latch;
    logic [AGC_WORD_W-1:0] out_instr;
    logic                  out_ext;
    logic [AGC_ADDR_W-1:0] out_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= START;
            pc         <= RESET_PC;
            ext_flag   <= 1'b0;
            redir_pend <= 1'b0;
            redir_addr <= '0;
            perr       <= 1'b0;
            out_instr  <= '0;
            out_ext    <= 1'b0;
            out_addr   <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ext_flag   <= ext_nxt;
            redir_pend <= pend_nxt;
            redir_addr <= raddr_nxt;
            perr       <= perr_nxt;
            if (latch) begin
                out_instr <= bus.mem_rdata[AGC_WORD_W-1:0];
                out_ext   <= ext_flag;
                out_addr  <= pc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ext_nxt   = ext_flag;
        pend_nxt  = redir_pend;
        raddr_nxt = redir_addr;
        perr_nxt  = perr;
        latch     = 1'b0;
        case (state)
            START: begin
                state_nxt = REQ;
                pc_nxt    = RESET_PC;
            end
            REQ: begin
                if (bus.mem_ready) begin
                    if (redir_pend || bus.pc_load) begin
                        // Word fetched from the stale address is dropped unchecked.
                        pc_nxt   = bus.pc_load ? bus.pc_load_addr : redir_addr;
                        pend_nxt = 1'b0;
                        ext_nxt  = 1'b0;
                    end else if (!odd_parity_ok(bus.mem_rdata)) begin
                        perr_nxt  = 1'b1;
                        state_nxt = HALT;
                    end else if (bus.mem_rdata[AGC_WORD_W-1:0] == EXTEND_WORD) begin
                        ext_nxt = 1'b1;
                        pc_nxt  = pc + 12'd1;
                    end else begin
                        latch     = 1'b1;
                        ext_nxt   = 1'b0;
                        pc_nxt    = pc + 12'd1;
                        state_nxt = HOLD;
                    end
                end else if (bus.pc_load) begin
                    // Address must stay stable until the memory answers.
                    pend_nxt  = 1'b1;
                    raddr_nxt = bus.pc_load_addr;
                    ext_nxt   = 1'b0;
                end
            end
            HOLD: begin
                if (bus.pc_load) begin
                    pc_nxt    = bus.pc_load_addr;
                    ext_nxt   = 1'b0;
                    state_nxt = REQ;
                end else if (bus.instr_ready) begin
                    state_nxt = REQ;
                end
            end
            HALT: ;
            default: state_nxt = START;
        endcase
    end

    assign bus.mem_req     = (state == REQ);
    assign bus.mem_addr    = pc;
    assign bus.instr_valid = (state == HOLD);
    assign bus.instr       = out_instr;
    assign bus.instr_ext   = out_ext;
    assign bus.instr_addr  = out_addr;
    assign bus.parity_err  = perr;

endmodule

// File: tb/tb_agc_instr_fetcher.sv
// Directed bench for agc_instr_fetcher with a latency-programmable memory model.
module tb_agc_instr_fetcher;
    import agc_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    agc_instr_fetcher_if bus();

    agc_instr_fetcher dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [15:0] mem [0:4095];
    int lat = 0;
    int cnt = 0;
    int hs_cnt = 0;

    function automatic logic [15:0] enc(input logic [14:0] d);
        return {~^d, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory answers after `lat` wait cycles of an asserted request.
    always @(negedge clk) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0;
        if (rst_n && bus.mem_req) begin
            if (cnt >= lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                cnt = 0;
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
        end
    end

    always @(posedge clk)
        if (rst_n && bus.instr_valid && bus.instr_ready) hs_cnt++;

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        bus.instr_ready = 1'b0;
        bus.pc_load = 1'b0;
        bus.pc_load_addr = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.instr_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    endtask

    task automatic accept();
        @(negedge clk);
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
    endtask

    initial begin
        int bad, held, h0, n;
        bus.instr_ready = 1'b0;
        bus.pc_load = 1'b0;
        bus.pc_load_addr = '0;
        for (int a = 0; a < 4096; a++) mem[a] = enc(15'(a) + 15'h100);

        // reset values and first fetch
        mem[12'h800] = enc(15'h0001);
        reset_dut();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h800);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_ext", 32'(bus.instr_ext), 32'd0);
        chk("rst_iaddr", 32'(bus.instr_addr), 32'd0);
        chk("rst_perr", 32'(bus.parity_err), 32'd0);
        rst_n = 1'b1;
        #1 chk("start_no_req", 32'(bus.mem_req), 32'd0);
        wait_valid("first");
        chk("first_instr", 32'(bus.instr), 32'h0001);
        chk("first_ext", 32'(bus.instr_ext), 32'd0);
        chk("first_addr", 32'(bus.instr_addr), 32'h800);
        chk("first_hold_req", 32'(bus.mem_req), 32'd0);
        accept();
        chk("next_req", 32'(bus.mem_req), 32'd1);
        chk("next_addr", 32'(bus.mem_addr), 32'h801);
        chk("next_valid", 32'(bus.instr_valid), 32'd0);

        // EXTEND fold and backpressure
        mem[12'h800] = enc(15'h0006);
        mem[12'h801] = enc(15'h3012);
        reset_dut();
        rst_n = 1'b1;
        h0 = hs_cnt;
        wait_valid("ext");
        chk("ext_instr", 32'(bus.instr), 32'h3012);
        chk("ext_flag", 32'(bus.instr_ext), 32'd1);
        chk("ext_addr", 32'(bus.instr_addr), 32'h801);
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.instr !== 15'h3012 || !bus.instr_valid || bus.mem_req) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        accept();
        chk("bp_req", 32'(bus.mem_req), 32'd1);
        chk("bp_addr", 32'(bus.mem_addr), 32'h802);
        chk("ext_single_hs", 32'(hs_cnt - h0), 32'd1);

        // redirect from HOLD to the top of memory, then wrap
        wait_valid("plain");
        chk("plain_addr", 32'(bus.instr_addr), 32'h802);
        chk("plain_instr", 32'(bus.instr), 32'h902);
        chk("plain_ext", 32'(bus.instr_ext), 32'd0);
        mem[12'h000] = enc(15'h0006);
        mem[12'h001] = 16'h8abc;
        @(negedge clk);
        bus.pc_load = 1'b1;
        bus.pc_load_addr = 12'hFFF;
        @(posedge clk); #1;
        bus.pc_load = 1'b0;
        chk("redir_valid_drop", 32'(bus.instr_valid), 32'd0);
        chk("redir_req", 32'(bus.mem_req), 32'd1);
        chk("redir_addr", 32'(bus.mem_addr), 32'hFFF);
        wait_valid("wrap");
        chk("wrap_iaddr", 32'(bus.instr_addr), 32'hFFF);
        chk("wrap_instr", 32'(bus.instr), 32'h10FF);
        lat = 4;
        accept();
        chk("wrap_req", 32'(bus.mem_req), 32'd1);
        chk("wrap_addr", 32'(bus.mem_addr), 32'h000);

        // redirect while the memory stalls; EXTEND at 000 leaves the flag pending
        n = 0;
        while (bus.mem_addr !== 12'h001 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ext_pending_addr", 32'(bus.mem_addr), 32'h001);
        held = 0;
        bad = 0;
        h0 = hs_cnt;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus.pc_load = (i < 2);
            bus.pc_load_addr = (i == 0) ? 12'h456 : 12'h123;
            @(posedge clk); #1;
            if (bus.instr_valid) bad++;
            if (bus.mem_addr === 12'h123 && bus.mem_req) break;
            if (bus.mem_addr === 12'h001 && bus.mem_req) held++;
            else bad++;
        end
        @(negedge clk);
        bus.pc_load = 1'b0;
        chk("stall_held", 32'(held >= 3), 32'd1);
        chk("stall_bad", 32'(bad), 32'd0);
        chk("stall_new_addr", 32'(bus.mem_addr), 32'h123);
        wait_valid("redir");
        chk("redir_iaddr", 32'(bus.instr_addr), 32'h123);
        chk("redir_instr", 32'(bus.instr), 32'h223);
        chk("redir_ext_clr", 32'(bus.instr_ext), 32'd0);
        chk("redir_no_hs", 32'(hs_cnt - h0), 32'd0);

        // parity failure halts until reset, redirects ignored
        lat = 0;
        mem[12'h124] = 16'h8001;
        accept();
        repeat (3) @(posedge clk);
        #1 chk("perr_set", 32'(bus.parity_err), 32'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.pc_load = (i == 2);
            bus.pc_load_addr = 12'h200;
            @(posedge clk); #1;
            if (bus.mem_req || bus.instr_valid || !bus.parity_err) bad++;
        end
        chk("halt_quiet", 32'(bad), 32'd0);

        // reset clears the halt; two EXTENDs fold into one flagged instruction
        mem[12'h800] = enc(15'h0006);
        mem[12'h801] = enc(15'h0006);
        mem[12'h802] = enc(15'h0777);
        reset_dut();
        chk("perr_cleared", 32'(bus.parity_err), 32'd0);
        rst_n = 1'b1;
        wait_valid("ext2");
        chk("ext2_addr", 32'(bus.instr_addr), 32'h802);
        chk("ext2_flag", 32'(bus.instr_ext), 32'd1);
        chk("ext2_instr", 32'(bus.instr), 32'h0777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
